// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: picks next_pc/pc_en from sequential, branch, exception and eret
// requests, holding a redirect that arrives while instruction memory is busy.
module fetch_redirect_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
   parameter logic [31:0] TEXT_HI    = 32'h0000_4ffc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] next_pc,
   output logic        pc_en,
   output logic        flush_pipe,
   output logic [4:0]  excode_F,
   output logic        pend_valid
);

   localparam int unsigned PC_W = 32;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   typedef enum logic {RUN, PEND} state_t;
   typedef enum logic [1:0] {K_NONE, K_BR, K_ERET, K_EXC} kind_t;

   state_t            state;
   kind_t             pend_kind;
   logic [PC_W-1:0]   pend_tgt;

   logic              br_eff;
   logic              eret_eff;
   kind_t             sel_kind;
   logic [PC_W-1:0]   sel_tgt;
   logic [PC_W-1:0]   seq_pc;

   assign br_eff   = br_taken & ~stall;
   assign eret_eff = eret_req & ~exc_req;
   assign seq_pc   = pc + PC_W'(4);

   // Merge any latched redirect with this cycle's requests; a newer request of
   // equal or higher priority replaces what is held.
   always_comb begin
      sel_kind = K_NONE;
      sel_tgt  = '0;
      if (state == PEND) begin
         sel_kind = pend_kind;
         sel_tgt  = pend_tgt;
      end
      if (exc_req) begin
         sel_kind = K_EXC;
         sel_tgt  = EXC_VECTOR;
      end else if (eret_eff && (sel_kind != K_EXC)) begin
         sel_kind = K_ERET;
         sel_tgt  = epc;
      end else if (br_eff && ((sel_kind == K_NONE) || (sel_kind == K_BR))) begin
         sel_kind = K_BR;
         sel_tgt  = br_target;
      end
   end

   // Fetch-stage address fault check, independent of redirect state.
   always_comb begin
      excode_F = '0;
      if ((pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc > TEXT_HI)) begin
         excode_F = EXC_ADEL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         pend_kind  <= K_NONE;
         pend_tgt   <= '0;
         next_pc    <= RESET_PC;
         pc_en      <= 1'b0;
         flush_pipe <= 1'b0;
         pend_valid <= 1'b0;
      end else begin
         flush_pipe <= 1'b0;
         pc_en      <= 1'b0;
         next_pc    <= seq_pc;
         case (state)
            RUN: begin
               if (imem_ready) begin
                  if (sel_kind != K_NONE) begin
                     next_pc    <= sel_tgt;
                     pc_en      <= 1'b1;
                     flush_pipe <= (sel_kind == K_EXC) || (sel_kind == K_ERET);
                  end else begin
                     pc_en <= ~stall;
                  end
                  pend_valid <= 1'b0;
               end else if (sel_kind != K_NONE) begin
                  state      <= PEND;
                  pend_kind  <= sel_kind;
                  pend_tgt   <= sel_tgt;
                  pend_valid <= 1'b1;
               end else begin
                  pend_valid <= 1'b0;
               end
            end
            PEND: begin
               if (imem_ready) begin
                  next_pc    <= sel_tgt;
                  pc_en      <= 1'b1;
                  flush_pipe <= (sel_kind == K_EXC) || (sel_kind == K_ERET);
                  state      <= RUN;
                  pend_kind  <= K_NONE;
                  pend_tgt   <= '0;
                  pend_valid <= 1'b0;
               end else begin
                  pend_kind  <= sel_kind;
                  pend_tgt   <= sel_tgt;
                  pend_valid <= 1'b1;
               end
            end
            default: begin
               state      <= RUN;
               pend_kind  <= K_NONE;
               pend_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
